// File: rtl/tdpram_pa_burst_ctrl.sv
// tdpram_pa_burst_ctrl: burst sequencer for RAM port A with a credit-limited read FIFO
module tdpram_pa_burst_ctrl #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int BYTE_NUM = 8,
    parameter int RD_LAT   = 2,
    parameter int LEN_W    = 8,
    localparam int BEW     = DW / BYTE_NUM
) (
    input  logic             clk_pa,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    input  logic [BEW-1:0]   wr_be,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DW-1:0]    rd_data,
    output logic             done,
    output logic             pa_wr,
    output logic [BEW-1:0]   pa_wea,
    output logic [AW-1:0]    pa_addr,
    output logic [DW-1:0]    pa_wdata,
    input  logic [DW-1:0]    pa_rdata
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     addr;
    logic [LEN_W-1:0]  cnt;
    logic [RD_LAT-1:0] vld;
    logic [DW-1:0]     fifo [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     occ, infl;
    logic              wr_hs, iss, beat, last, push, pop, fin;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) infl = infl + CW'(vld[i]);
    end

    // a read is issued only if its data is guaranteed a FIFO slot on arrival
    assign wr_hs = state == WRITE && wr_valid;
    assign iss   = state == READ && ({1'b0, infl} + {1'b0, occ}) < DEPTH_L;
    assign beat  = wr_hs || iss;
    assign last  = beat && cnt == '0;
    assign push  = vld[RD_LAT-1];
    assign pop   = rd_valid && rd_ready;
    assign fin   = state == DRAIN && pop && occ == CW'(1) && infl == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? (cmd_rw ? READ : WRITE) : IDLE;
            WRITE:   state_nx = last ? IDLE : WRITE;
            READ:    state_nx = last ? DRAIN : READ;
            DRAIN:   state_nx = fin ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_pa or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            vld   <= '0;
            wp    <= '0;
            rp    <= '0;
            occ   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == WRITE && last) || fin;
            vld   <= (vld << 1) | RD_LAT'(iss);
            occ   <= occ + CW'(push) - CW'(pop);
            if (push)
                wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop)
                rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            if (state == IDLE && cmd_valid) begin
                addr <= cmd_addr;
                cnt  <= cmd_len;
            end else if (beat) begin
                addr <= addr + 1'b1;
                if (!last)
                    cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pa)
        if (push)
            fifo[wp] <= pa_rdata;

    assign cmd_ready = state == IDLE;
    assign wr_ready  = state == WRITE;
    assign rd_valid  = occ != '0;
    assign rd_data   = rd_valid ? fifo[rp] : '0;
    assign pa_wr     = wr_hs;
    assign pa_wea    = wr_hs ? wr_be : '0;
    assign pa_addr   = addr;
    assign pa_wdata  = wr_hs ? wr_data : '0;
endmodule

// File: tb/tb_tdpram_pa_burst_ctrl.sv
// tb_tdpram_pa_burst_ctrl: directed bench driving RD_LAT=2 and RD_LAT=1 controllers in lockstep, each with its own RAM
module tb_tdpram_pa_burst_ctrl;
    logic       clk_pa = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic [0:0] wr_be = '0;
    logic       rd_ready = 1'b0;
    logic       cmd_ready1, cmd_ready2, wr_ready1, wr_ready2, rd_valid1, rd_valid2;
    logic       done1, done2, pa_wr1, pa_wr2;
    logic [0:0] pa_wea1, pa_wea2;
    logic [7:0] rd_data1, rd_data2, pa_addr1, pa_addr2, pa_wdata1, pa_wdata2;
    logic [7:0] pa_rdata1, pa_rdata2;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] r1a, r2a, r2b;
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         dn1, dn2, dc1, dc2, ac1, ac2;

    always #5 clk_pa = ~clk_pa;

    tdpram_pa_burst_ctrl #(.DW(8), .AW(8), .BYTE_NUM(8), .RD_LAT(2), .LEN_W(8)) u2 (
        .clk_pa(clk_pa), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready2), .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid2),
        .rd_ready(rd_ready), .rd_data(rd_data2), .done(done2), .pa_wr(pa_wr2),
        .pa_wea(pa_wea2), .pa_addr(pa_addr2), .pa_wdata(pa_wdata2), .pa_rdata(pa_rdata2)
    );

    tdpram_pa_burst_ctrl #(.DW(8), .AW(8), .BYTE_NUM(8), .RD_LAT(1), .LEN_W(8)) u1 (
        .clk_pa(clk_pa), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready1), .wr_data(wr_data), .wr_be(wr_be), .rd_valid(rd_valid1),
        .rd_ready(rd_ready), .rd_data(rd_data1), .done(done1), .pa_wr(pa_wr1),
        .pa_wea(pa_wea1), .pa_addr(pa_addr1), .pa_wdata(pa_wdata1), .pa_rdata(pa_rdata1)
    );

    always @(posedge clk_pa) begin
        if (pa_wr2 && pa_wea2[0]) mem2[pa_addr2] <= pa_wdata2;
        if (pa_wr1 && pa_wea1[0]) mem1[pa_addr1] <= pa_wdata1;
        r2a <= mem2[pa_addr2];
        r2b <= r2a;
        r1a <= mem1[pa_addr1];
    end
    assign pa_rdata2 = r2b;
    assign pa_rdata1 = r1a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_cmd_ready"}, {cmd_ready2, cmd_ready1}, 2'b11);
        chk({tag, "_wr_ready"}, {wr_ready2, wr_ready1}, 2'b00);
        chk({tag, "_rd_valid"}, {rd_valid2, rd_valid1}, 2'b00);
        chk({tag, "_rd_data"}, {rd_data2, rd_data1}, 16'h0);
        chk({tag, "_done"}, {done2, done1}, 2'b00);
        chk({tag, "_pa_wr"}, {pa_wr2, pa_wr1}, 2'b00);
        chk({tag, "_pa_wea"}, {pa_wea2, pa_wea1}, 2'b00);
        chk({tag, "_pa_addr"}, {pa_addr2, pa_addr1}, 16'h0);
        chk({tag, "_pa_wdata"}, {pa_wdata2, pa_wdata1}, 16'h0);
    endtask

    task automatic cmd(input logic rw, input logic [7:0] a, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_len = len;
        #1 chk("cmd_ready", {cmd_ready2, cmd_ready1}, 2'b11);
        @(negedge clk_pa);
        cmd_valid = 1'b0;
        #1 chk("busy_cmd_ready", {cmd_ready2, cmd_ready1}, 2'b00);
        chk("busy_wr_ready", {wr_ready2, wr_ready1}, rw ? 2'b00 : 2'b11);
    endtask

    task automatic wr_beat(input logic [7:0] d, input logic be, input logic [7:0] a);
        wr_valid = 1'b1;
        wr_data = d;
        wr_be = be;
        #1 chk("pa_wr", {pa_wr2, pa_wr1}, 2'b11);
        chk("pa_addr", {pa_addr2, pa_addr1}, {a, a});
        chk("pa_wdata", {pa_wdata2, pa_wdata1}, {d, d});
        chk("pa_wea", {pa_wea2, pa_wea1}, {be, be});
        @(negedge clk_pa);
        wr_valid = 1'b0;
    endtask

    task automatic wr_gap();
        wr_valid = 1'b0;
        wr_data = 8'hEE;
        wr_be = 1'b1;
        #1 chk("gap_pa_wr", {pa_wr2, pa_wr1}, 2'b00);
        chk("gap_pa_wea", {pa_wea2, pa_wea1}, 2'b00);
        chk("gap_wr_ready", {wr_ready2, wr_ready1}, 2'b11);
        @(negedge clk_pa);
    endtask

    task automatic wr_end();
        #1 chk("wr_done", {done2, done1}, 2'b11);
        chk("wr_done_cmd_ready", {cmd_ready2, cmd_ready1}, 2'b11);
        chk("wr_done_wr_ready", {wr_ready2, wr_ready1}, 2'b00);
        chk("wr_done_pa_wr", {pa_wr2, pa_wr1}, 2'b00);
        @(negedge clk_pa);
        #1 chk("wr_done_pulse", {done2, done1}, 2'b00);
        @(negedge clk_pa);
    endtask

    task automatic rd_run(input logic [7:0] a, input int stall);
        logic [7:0] e2, e1;
        e2 = a + 8'd4;
        e1 = a + 8'd3;
        q1.delete();
        q2.delete();
        dn1 = 0; dn2 = 0; dc1 = -1; dc2 = -1; ac1 = -9; ac2 = -9;
        for (int i = 0; i < 40; i++) begin
            rd_ready = i >= stall;
            #1 chk("rd_pa_wr", {pa_wr2, pa_wr1}, 2'b00);
            if (stall > 0 && i == stall - 1) begin
                chk("stall_addr_lat2", pa_addr2, e2);
                chk("stall_addr_lat1", pa_addr1, e1);
                chk("stall_rd_valid", {rd_valid2, rd_valid1}, 2'b11);
            end
            if (rd_valid2 && rd_ready) begin q2.push_back(rd_data2); ac2 = i; end
            if (rd_valid1 && rd_ready) begin q1.push_back(rd_data1); ac1 = i; end
            if (done2) begin dn2++; dc2 = i; end
            if (done1) begin dn1++; dc1 = i; end
            @(negedge clk_pa);
        end
        rd_ready = 1'b0;
        chk("rd_count_lat2", q2.size(), exp_q.size());
        chk("rd_count_lat1", q1.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            chk("rd_data_lat2", q2[k], exp_q[k]);
            chk("rd_data_lat1", q1[k], exp_q[k]);
        end
        chk("rd_done_count_lat2", dn2, 1);
        chk("rd_done_count_lat1", dn1, 1);
        chk("rd_done_time_lat2", dc2, ac2 + 1);
        chk("rd_done_time_lat1", dc1, ac1 + 1);
        chk("rd_end_idle", {cmd_ready2, cmd_ready1, rd_valid2, rd_valid1}, 4'b1100);
    endtask

    initial begin
        #2 rst_chk("reset");
        @(negedge clk_pa);
        rst_n = 1'b1;
        @(negedge clk_pa);
        cmd(1'b0, 8'h10, 8'd3);
        for (int i = 0; i < 4; i++) wr_beat(8'hA0 + 8'(i), 1'b1, 8'h10 + 8'(i));
        wr_end();
        cmd(1'b1, 8'h10, 8'd3);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        rd_run(8'h10, 0);
        cmd(1'b0, 8'hFE, 8'd2);
        wr_beat(8'hC0, 1'b1, 8'hFE);
        wr_beat(8'hC1, 1'b1, 8'hFF);
        wr_beat(8'hC2, 1'b1, 8'h00);
        wr_end();
        cmd(1'b1, 8'hFE, 8'd2);
        exp_q = '{8'hC0, 8'hC1, 8'hC2};
        rd_run(8'hFE, 0);
        cmd(1'b0, 8'h20, 8'd7);
        for (int i = 0; i < 8; i++) wr_beat(8'h30 + 8'(i), 1'b1, 8'h20 + 8'(i));
        wr_end();
        cmd(1'b1, 8'h20, 8'd7);
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
        rd_run(8'h20, 10);
        cmd(1'b0, 8'h24, 8'd2);
        wr_beat(8'h11, 1'b1, 8'h24);
        wr_gap();
        wr_beat(8'h22, 1'b0, 8'h25);
        wr_gap();
        wr_gap();
        wr_beat(8'h33, 1'b1, 8'h26);
        wr_end();
        cmd(1'b1, 8'h24, 8'd2);
        exp_q = '{8'h11, 8'h35, 8'h33};
        rd_run(8'h24, 0);
        cmd(1'b0, 8'h20, 8'd5);
        wr_beat(8'h60, 1'b1, 8'h20);
        wr_beat(8'h61, 1'b1, 8'h21);
        wr_valid = 1'b1;
        wr_data = 8'h62;
        wr_be = 1'b1;
        #1 rst_n = 1'b0;
        #1 rst_chk("midrst");
        @(negedge clk_pa);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        #1 chk("midrst_no_done_a", {done2, done1}, 2'b00);
        @(negedge clk_pa);
        #1 chk("midrst_no_done_b", {done2, done1}, 2'b00);
        @(negedge clk_pa);
        cmd(1'b1, 8'h20, 8'd2);
        exp_q = '{8'h60, 8'h61, 8'h32};
        rd_run(8'h20, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
